l1_refill_ctrl: RTL and testbench

Miss-refill controller for the L1 cache, sitting directly downstream of `l1_addr_decoder`. On a decoder miss it fetches the whole line from next-level memory and writes each beat into the data array. It then writes the tag into the victim way, which makes the line valid. Victim ways are chosen round-robin per index.

---
 rtl/l1_cache_pkg.sv | 35 +++
 rtl/l1_refill_ctrl_if.sv | 42 ++++
 rtl/l1_victim_sel.sv | 34 +++
 rtl/l1_refill_ctrl.sv | 150 +++++++++++++++
 tb/tb_l1_refill_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l1_cache_pkg.sv
// rtl/l1_cache_pkg.sv - shared L1 address layout, widths and refill FSM states
package l1_cache_pkg;

    localparam int SET_NUMBER   = 8;
    localparam int BLOCK_NUMBER = 128;
    localparam int BLOCK_SIZE   = 32;
    localparam int ADDR_WIDTH   = 32;
    localparam int DATA_WIDTH   = 32;

    localparam int WAY_W   = $clog2(SET_NUMBER);
    localparam int INDEX_W = $clog2(BLOCK_NUMBER / SET_NUMBER);
    localparam int WORD_W  = $clog2(BLOCK_SIZE);
    localparam int TAG_LSB = WORD_W + 2 + INDEX_W;
    localparam int TAG_W   = ADDR_WIDTH - TAG_LSB;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_FILL   = 2'd2,
        ST_COMMIT = 2'd3
    } refill_state_e;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] addr);
        return TAG_W'(addr >> TAG_LSB);
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_WIDTH-1:0] addr);
        return INDEX_W'(addr >> (WORD_W + 2));
    endfunction

    function automatic logic [WORD_W-1:0] addr_word(input logic [ADDR_WIDTH-1:0] addr);
        return WORD_W'(addr >> 2);
    endfunction

endpackage

// File: rtl/l1_refill_ctrl_if.sv
// rtl/l1_refill_ctrl_if.sv - miss, memory and array-write bundle of the refill controller
interface l1_refill_if
    import l1_cache_pkg::*;
#(
    parameter int P_ADDR_WIDTH = ADDR_WIDTH,
    parameter int P_DATA_WIDTH = DATA_WIDTH,
    parameter int P_WAY_W      = WAY_W,
    parameter int P_INDEX_W    = INDEX_W,
    parameter int P_WORD_W     = WORD_W,
    parameter int P_TAG_W      = TAG_W
);
    logic                                  miss_val;
    logic [P_ADDR_WIDTH-1:0]               miss_addr;
    logic                                  miss_rdy;
    logic                                  mem_req_val;
    logic [P_ADDR_WIDTH-1:0]               mem_req_addr;
    logic                                  mem_req_rdy;
    logic                                  mem_rsp_val;
    logic [P_DATA_WIDTH-1:0]               mem_rsp_data;
    logic                                  data_wr_val;
    logic [P_WAY_W+P_INDEX_W+P_WORD_W-1:0] data_wr_addr;
    logic [P_DATA_WIDTH-1:0]               data_wr_data;
    logic                                  tag_wr_val;
    logic [P_WAY_W-1:0]                    tag_wr_way;
    logic [P_INDEX_W-1:0]                  tag_wr_index;
    logic [P_TAG_W-1:0]                    tag_wr_data;
    logic                                  refill_done;

    modport master (
        input  miss_val, miss_addr, mem_req_rdy, mem_rsp_val, mem_rsp_data,
        output miss_rdy, mem_req_val, mem_req_addr,
        output data_wr_val, data_wr_addr, data_wr_data,
        output tag_wr_val, tag_wr_way, tag_wr_index, tag_wr_data, refill_done
    );

    modport slave (
        output miss_val, miss_addr, mem_req_rdy, mem_rsp_val, mem_rsp_data,
        input  miss_rdy, mem_req_val, mem_req_addr,
        input  data_wr_val, data_wr_addr, data_wr_data,
        input  tag_wr_val, tag_wr_way, tag_wr_index, tag_wr_data, refill_done
    );
endinterface

// File: rtl/l1_victim_sel.sv
// rtl/l1_victim_sel.sv - per-index round-robin victim way pointers
module l1_victim_sel #(
    parameter int SET_NUMBER = 8,
    parameter int INDEX_W    = 4,
    parameter int WAY_W      = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] i_rd_index,
    output logic [WAY_W-1:0]   o_rd_way,
    input  logic               i_adv,
    input  logic [INDEX_W-1:0] i_adv_index
);
    localparam int DEPTH = 1 << INDEX_W;

    logic [WAY_W-1:0] r_ptr [DEPTH];

    assign o_rd_way = r_ptr[i_rd_index];

    // Explicit wrap so non-power-of-two way counts never select a missing way
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ptr[i] <= '0;
            end
        end else if (i_adv) begin
            if (r_ptr[i_adv_index] == WAY_W'(SET_NUMBER - 1)) begin
                r_ptr[i_adv_index] <= '0;
            end else begin
                r_ptr[i_adv_index] <= r_ptr[i_adv_index] + 1'b1;
            end
        end
    end
endmodule

// File: rtl/l1_refill_ctrl.sv
// rtl/l1_refill_ctrl.sv - L1 miss refill: line read, beat writes into the data array, then tag commit
module l1_refill_ctrl #(
    parameter int SET_NUMBER   = 8,
    parameter int BLOCK_NUMBER = 128,
    parameter int BLOCK_SIZE   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    l1_refill_if.master   bus
);
    import l1_cache_pkg::*;

    localparam int WAY_W   = $clog2(SET_NUMBER);
    localparam int INDEX_W = $clog2(BLOCK_NUMBER / SET_NUMBER);
    localparam int WORD_W  = $clog2(BLOCK_SIZE);
    localparam int TAG_LSB = WORD_W + 2 + INDEX_W;
    localparam int TAG_W   = ADDR_WIDTH - TAG_LSB;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << (WORD_W + 2);

    refill_state_e r_state;
    refill_state_e w_state_nxt;

    logic [ADDR_WIDTH-1:0]             r_line_addr;
    logic [WAY_W-1:0]                  r_way;
    logic [WORD_W-1:0]                 r_beat;
    logic                              r_data_wr_val;
    logic [WAY_W+INDEX_W+WORD_W-1:0]   r_data_wr_addr;
    logic [DATA_WIDTH-1:0]             r_data_wr_data;
    logic                              r_tag_wr_val;
    logic [WAY_W-1:0]                  r_tag_wr_way;
    logic [INDEX_W-1:0]                r_tag_wr_index;
    logic [TAG_W-1:0]                  r_tag_wr_data;
    logic                              r_refill_done;

    logic                              w_miss_rdy;
    logic                              w_mem_req_val;
    logic                              w_accept;
    logic                              w_beat;
    logic                              w_last_beat;
    logic                              w_commit;
    logic [INDEX_W-1:0]                w_miss_index;
    logic [INDEX_W-1:0]                w_line_index;
    logic [TAG_W-1:0]                  w_line_tag;
    logic [WAY_W-1:0]                  w_victim_way;

    assign w_miss_index = INDEX_W'(bus.miss_addr >> (WORD_W + 2));
    assign w_line_index = INDEX_W'(r_line_addr >> (WORD_W + 2));
    assign w_line_tag   = TAG_W'(r_line_addr >> TAG_LSB);

    assign w_accept    = (r_state == ST_IDLE) && bus.miss_val;
    assign w_beat      = (r_state == ST_FILL) && bus.mem_rsp_val;
    assign w_last_beat = w_beat && (r_beat == WORD_W'(BLOCK_SIZE - 1));
    assign w_commit    = (r_state == ST_COMMIT);

    l1_victim_sel #(
        .SET_NUMBER (SET_NUMBER),
        .INDEX_W    (INDEX_W),
        .WAY_W      (WAY_W)
    ) u_victim_sel (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rd_index  (w_miss_index),
        .o_rd_way    (w_victim_way),
        .i_adv       (w_commit),
        .i_adv_index (w_line_index)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_miss_rdy    = 1'b0;
        w_mem_req_val = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_miss_rdy = 1'b1;
                if (bus.miss_val) w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                w_mem_req_val = 1'b1;
                if (bus.mem_req_rdy) w_state_nxt = ST_FILL;
            end
            ST_FILL: begin
                if (w_last_beat) w_state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Tag strobe is registered off the last beat, landing together with the final data write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line_addr    <= '0;
            r_way          <= '0;
            r_beat         <= '0;
            r_data_wr_val  <= 1'b0;
            r_data_wr_addr <= '0;
            r_data_wr_data <= '0;
            r_tag_wr_val   <= 1'b0;
            r_tag_wr_way   <= '0;
            r_tag_wr_index <= '0;
            r_tag_wr_data  <= '0;
            r_refill_done  <= 1'b0;
        end else begin
            r_data_wr_val <= w_beat;
            r_tag_wr_val  <= w_last_beat;
            r_refill_done <= w_last_beat;
            if (w_accept) begin
                r_line_addr <= bus.miss_addr & LINE_MASK;
                r_way       <= w_victim_way;
            end
            if ((r_state == ST_REQ) && bus.mem_req_rdy) begin
                r_beat <= '0;
            end
            if (w_beat) begin
                r_beat         <= r_beat + 1'b1;
                r_data_wr_addr <= {r_way, w_line_index, r_beat};
                r_data_wr_data <= bus.mem_rsp_data;
            end
            if (w_last_beat) begin
                r_tag_wr_way   <= r_way;
                r_tag_wr_index <= w_line_index;
                r_tag_wr_data  <= w_line_tag;
            end
        end
    end

    assign bus.miss_rdy     = w_miss_rdy;
    assign bus.mem_req_val  = w_mem_req_val;
    assign bus.mem_req_addr = r_line_addr;
    assign bus.data_wr_val  = r_data_wr_val;
    assign bus.data_wr_addr = r_data_wr_addr;
    assign bus.data_wr_data = r_data_wr_data;
    assign bus.tag_wr_val   = r_tag_wr_val;
    assign bus.tag_wr_way   = r_tag_wr_way;
    assign bus.tag_wr_index = r_tag_wr_index;
    assign bus.tag_wr_data  = r_tag_wr_data;
    assign bus.refill_done  = r_refill_done;
endmodule

// File: tb/tb_l1_refill_ctrl.sv
// tb/tb_l1_refill_ctrl.sv - randomized self-checking bench for l1_refill_ctrl
module tb_l1_refill_ctrl;
    localparam int SET_NUMBER    = 8;
    localparam int BLOCK_NUMBER  = 128;
    localparam int BLOCK_SIZE    = 32;
    localparam int ADDR_WIDTH    = 32;
    localparam int DATA_WIDTH    = 32;
    localparam int WAY_W         = $clog2(SET_NUMBER);
    localparam int INDEX_W       = $clog2(BLOCK_NUMBER / SET_NUMBER);
    localparam int WORD_W        = $clog2(BLOCK_SIZE);
    localparam int TAG_W         = ADDR_WIDTH - (WORD_W + 2 + INDEX_W);
    localparam int LINES_PER_WAY = BLOCK_NUMBER / SET_NUMBER;
    localparam int LINE_BYTES    = BLOCK_SIZE * 4;
    localparam int DA_W          = WAY_W + INDEX_W + WORD_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    l1_refill_if #(
        .P_ADDR_WIDTH (ADDR_WIDTH),
        .P_DATA_WIDTH (DATA_WIDTH),
        .P_WAY_W      (WAY_W),
        .P_INDEX_W    (INDEX_W),
        .P_WORD_W     (WORD_W),
        .P_TAG_W      (TAG_W)
    ) bus ();

    l1_refill_ctrl #(
        .SET_NUMBER   (SET_NUMBER),
        .BLOCK_NUMBER (BLOCK_NUMBER),
        .BLOCK_SIZE   (BLOCK_SIZE),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int rr_model [LINES_PER_WAY];

    typedef struct packed {
        logic [DA_W-1:0]       addr;
        logic [DATA_WIDTH-1:0] data;
    } wr_t;

    wr_t got_wr [$];
    int  n_tag = 0;
    int  last_tag_way = -1;

    always @(negedge clk) begin
        wr_t w;
        if (bus.data_wr_val === 1'b1) begin
            w.addr = bus.data_wr_addr;
            w.data = bus.data_wr_data;
            got_wr.push_back(w);
        end
        if (bus.tag_wr_val === 1'b1) begin
            n_tag++;
            last_tag_way = int'(bus.tag_wr_way);
        end
    end

    function automatic bit outs_zero();
        return bus.mem_req_val === 1'b0 && bus.mem_req_addr === '0 &&
               bus.data_wr_val === 1'b0 && bus.data_wr_addr === '0 && bus.data_wr_data === '0 &&
               bus.tag_wr_val === 1'b0 && bus.tag_wr_way === '0 && bus.tag_wr_index === '0 &&
               bus.tag_wr_data === '0 && bus.refill_done === 1'b0;
    endfunction

    task automatic clear_inputs();
        bus.miss_val     = 1'b0;
        bus.miss_addr    = '0;
        bus.mem_req_rdy  = 1'b0;
        bus.mem_rsp_val  = 1'b0;
        bus.mem_rsp_data = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < LINES_PER_WAY; i++) rr_model[i] = 0;
        @(negedge clk);
        got_wr.delete();
    endtask

    // One whole refill: stimulus plus comparison against the line-level model
    task automatic do_refill(input logic [31:0] addr, input int rdy_delay, input int max_gap,
                             input bit spurious, input bit hold_miss, input int abort_after);
        int          idx, way, n, t_acc, n_before;
        logic [31:0] line, tag;
        logic [31:0] d;
        logic [DATA_WIDTH-1:0] exp_data [$];

        idx  = int'((addr / LINE_BYTES) % LINES_PER_WAY);
        line = addr - (addr % LINE_BYTES);
        tag  = addr / (LINE_BYTES * LINES_PER_WAY);
        way  = rr_model[idx];

        n = 0;
        while (bus.miss_rdy !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL miss_rdy_wait: miss_rdy=%b after %0d cycles, required 1", bus.miss_rdy, n);
        end

        bus.miss_val  = 1'b1;
        bus.miss_addr = addr;
        @(negedge clk);
        t_acc = cyc;
        if (!hold_miss) bus.miss_val = 1'b0;
        checks++;
        if (bus.mem_req_val !== 1'b1 || bus.mem_req_addr !== line || bus.miss_rdy !== 1'b0) begin
            failures++;
            $display("FAIL req_issue: val=%b addr=%h rdy=%b, required val=1 addr=%h rdy=0",
                     bus.mem_req_val, bus.mem_req_addr, bus.miss_rdy, line);
        end

        for (int i = 0; i < rdy_delay; i++) begin
            bus.mem_req_rdy  = 1'b0;
            bus.mem_rsp_val  = spurious && (i == 0);
            bus.mem_rsp_data = $urandom;
            @(negedge clk);
            checks++;
            if (bus.mem_req_val !== 1'b1 || bus.mem_req_addr !== line) begin
                failures++;
                $display("FAIL req_stall[%0d]: val=%b addr=%h, required val=1 addr=%h",
                         i, bus.mem_req_val, bus.mem_req_addr, line);
            end
        end

        bus.mem_req_rdy  = 1'b1;
        bus.mem_rsp_val  = spurious;
        bus.mem_rsp_data = $urandom;
        @(negedge clk);
        bus.mem_req_rdy = 1'b0;
        bus.mem_rsp_val = 1'b0;
        checks++;
        if (bus.mem_req_val !== 1'b0) begin
            failures++;
            $display("FAIL req_drop: mem_req_val=%b, required 0", bus.mem_req_val);
        end

        for (int b = 0; b < BLOCK_SIZE; b++) begin
            repeat ($urandom_range(max_gap, 0)) begin
                bus.mem_rsp_val = 1'b0;
                @(negedge clk);
            end
            d = $urandom;
            bus.mem_rsp_val  = 1'b1;
            bus.mem_rsp_data = d;
            exp_data.push_back(d);
            @(negedge clk);
            if (b == abort_after) begin
                bus.mem_rsp_val = 1'b0;
                n_before = n_tag;
                #2;
                rst_n = 1'b0;
                #1;
                checks++;
                if (!outs_zero()) begin
                    failures++;
                    $display("FAIL abort_outs: data_wr_val=%b tag_wr_val=%b req_val=%b, required all 0",
                             bus.data_wr_val, bus.tag_wr_val, bus.mem_req_val);
                end
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                for (int i = 0; i < LINES_PER_WAY; i++) rr_model[i] = 0;
                repeat (2) @(negedge clk);
                #1;
                checks++;
                if (n_tag !== n_before || bus.miss_rdy !== 1'b1) begin
                    failures++;
                    $display("FAIL abort_no_tag: tag writes=%0d miss_rdy=%b, required %0d and 1",
                             n_tag, bus.miss_rdy, n_before);
                end
                got_wr.delete();
                return;
            end
        end
        bus.mem_rsp_val = 1'b0;
        #1;

        checks++;
        if (bus.refill_done !== 1'b1 || bus.tag_wr_val !== 1'b1 || got_wr.size() != BLOCK_SIZE) begin
            failures++;
            $display("FAIL done_pulse: done=%b tag_val=%b writes=%0d, required 1 1 %0d",
                     bus.refill_done, bus.tag_wr_val, got_wr.size(), BLOCK_SIZE);
        end
        checks++;
        if (int'(bus.tag_wr_way) != way || int'(bus.tag_wr_index) != idx || bus.tag_wr_data !== tag[TAG_W-1:0]) begin
            failures++;
            $display("FAIL tag_fields: way=%0d index=%0d tag=%h, required %0d %0d %h",
                     bus.tag_wr_way, bus.tag_wr_index, bus.tag_wr_data, way, idx, tag[TAG_W-1:0]);
        end
        checks++;
        if (bus.miss_rdy !== 1'b0 || bus.mem_req_val !== 1'b0) begin
            failures++;
            $display("FAIL commit_busy: miss_rdy=%b req_val=%b, required 0 0", bus.miss_rdy, bus.mem_req_val);
        end
        if (rdy_delay == 0 && max_gap == 0) begin
            checks++;
            if (cyc - t_acc + 1 != BLOCK_SIZE + 2) begin
                failures++;
                $display("FAIL latency: done at cycle %0d, required %0d", cyc - t_acc + 1, BLOCK_SIZE + 2);
            end
        end

        @(negedge clk);
        #1;
        checks++;
        if (bus.miss_rdy !== 1'b1 || bus.refill_done !== 1'b0 || bus.tag_wr_val !== 1'b0 ||
            bus.data_wr_val !== 1'b0 || bus.mem_req_val !== 1'b0) begin
            failures++;
            $display("FAIL post_commit: rdy=%b done=%b tag=%b wr=%b req=%b, required 1 0 0 0 0",
                     bus.miss_rdy, bus.refill_done, bus.tag_wr_val, bus.data_wr_val, bus.mem_req_val);
        end

        checks++;
        if (got_wr.size() != BLOCK_SIZE) begin
            failures++;
            $display("FAIL write_count: %0d data writes, required %0d", got_wr.size(), BLOCK_SIZE);
        end
        for (int i = 0; i < BLOCK_SIZE && i < got_wr.size(); i++) begin
            logic [DA_W-1:0] ea;
            ea = DA_W'(way * LINES_PER_WAY * BLOCK_SIZE + idx * BLOCK_SIZE + i);
            checks++;
            if (got_wr[i].addr !== ea || got_wr[i].data !== exp_data[i]) begin
                failures++;
                $display("FAIL data_write[%0d]: addr=%h data=%h, required addr=%h data=%h",
                         i, got_wr[i].addr, got_wr[i].data, ea, exp_data[i]);
            end
        end
        got_wr.delete();
        rr_model[idx] = (way + 1) % SET_NUMBER;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (!outs_zero()) begin
            failures++;
            $display("FAIL reset_outs: req_val=%b wr_val=%b tag_val=%b done=%b, required all 0",
                     bus.mem_req_val, bus.data_wr_val, bus.tag_wr_val, bus.refill_done);
        end
        rst_n = 1'b1;
        for (int i = 0; i < LINES_PER_WAY; i++) rr_model[i] = 0;
        @(negedge clk);
        checks++;
        if (bus.miss_rdy !== 1'b1 || !outs_zero()) begin
            failures++;
            $display("FAIL reset_release: miss_rdy=%b, required 1 with outputs 0", bus.miss_rdy);
        end
    endtask

    task automatic test_single_miss();
        do_refill(32'h1234_5680, 0, 0, 1'b0, 1'b0, -1);
        checks++;
        if (last_tag_way != 0) begin
            failures++;
            $display("FAIL single_way: way=%0d, required 0", last_tag_way);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] a;
        int          k;
        do_reset();
        k = 0;
        for (int step = 0; step < 10; step++) begin
            if (step == 4) begin
                a = ($urandom & 32'hFFFF_F800) | (32'd9 << 7) | $urandom_range(127, 0);
                do_refill(a, 0, 1, 1'b0, 1'b0, -1);
                checks++;
                if (last_tag_way != 0) begin
                    failures++;
                    $display("FAIL rr_other_index: way=%0d, required 0", last_tag_way);
                end
            end else begin
                a = ($urandom & 32'hFFFF_F800) | (32'd5 << 7) | $urandom_range(127, 0);
                do_refill(a, 0, 1, 1'b0, 1'b0, -1);
                checks++;
                if (last_tag_way != k % SET_NUMBER) begin
                    failures++;
                    $display("FAIL rr_seq[%0d]: way=%0d, required %0d", k, last_tag_way, k % SET_NUMBER);
                end
                k++;
            end
        end
    endtask

    task automatic test_req_stall();
        do_refill($urandom, 5, 0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_gaps_spurious();
        do_refill($urandom, 2, 3, 1'b1, 1'b0, -1);
        do_refill($urandom, 0, 3, 1'b1, 1'b0, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            do_refill($urandom, $urandom_range(3, 0), $urandom_range(2, 0), 1'($urandom), 1'b0, -1);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a;
        a = ($urandom & 32'hFFFF_F800) | (32'd3 << 7);
        do_refill(a, 0, 0, 1'b0, 1'b0, -1);
        do_refill(a + 32'h800, 0, 0, 1'b0, 1'b0, 10);
        do_refill(a, 0, 0, 1'b0, 1'b0, -1);
        checks++;
        if (last_tag_way != 0) begin
            failures++;
            $display("FAIL abort_rr: way=%0d, required 0", last_tag_way);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        a = $urandom;
        do_refill(a, 0, 0, 1'b0, 1'b1, -1);
        checks++;
        if (bus.miss_val !== 1'b1 || bus.mem_req_val !== 1'b0) begin
            failures++;
            $display("FAIL b2b_early: miss_val=%b req_val=%b, required 1 0", bus.miss_val, bus.mem_req_val);
        end
        do_refill(a, 0, 0, 1'b0, 1'b0, -1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_miss();
        test_round_robin();
        test_req_stall();
        test_gaps_spurious();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
